gpu_cv_cmd_loader: RTL and testbench
====================================

GPU_CV_CMD_LOADER -- requirements
Module: gpu_cv_cmd_loader

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named as the codebase does:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous active-high reset.

REQ-002 SHALL expose these GP0 port signals:
- i_gp0Valid  in  1  GP0 word present.
- i_gp0Data  in  32  GP0 word.
- o_gp0Ready  out  1  word accepted when valid&ready.

REQ-003 SHALL expose these copy-SM control signals:
- o_activateCopyCV  out  1  one-cycle start pulse to the CPU->VRAM copy SM.
- i_copyActive  in  1  copy SM busy.
- i_copyInactiveNextCycle  in  1  copy SM finishing.

REQ-004 SHALL expose these register outputs:
- o_RegX0  out  12 signed  destination X.
- o_RegY0  out  12 signed  destination Y.
- o_RegSizeW  out  11  width.
- o_RegSizeH  out  10  height.

REQ-005 SHALL expose these FIFO-side signals:
- i_canWriteFIFO  in  1  pixel FIFO pair not full.
- o_fifowrite  out  1  write strobe.
- o_fifoDataIn  out  32  two pixels; [15:0] first, [31:16] second.

REQ-006 SHALL expose these status outputs:
- o_busy  out  1  not IDLE.
- o_dropCmd  out  1  one-cycle pulse when a non-copy command word is discarded.

Function
REQ-007 SHALL implement states IDLE, GET_XY, GET_WH, START, STREAM, DRAIN.

REQ-008 o_gp0Ready SHALL be:
- 1 in IDLE, GET_XY and GET_WH;
- i_canWriteFIFO in STREAM;
- 0 in START and DRAIN.

REQ-009 IDLE transitions on an accepted word:
- if i_gp0Data[31:29]==3'b101, go to GET_XY;
- otherwise, pulse o_dropCmd and stay in IDLE.

REQ-010 GET_XY, on an accepted word:
- o_RegX0 = {2'b0, d[9:0]};
- o_RegY0 = {3'b0, d[24:16]};
- go to GET_WH.

REQ-011 GET_WH, on an accepted word:
- o_RegSizeW = ((d[15:0]-1) & 0x3FF)+1, so raw 0 gives 1024;
- o_RegSizeH = ((d[31:16]-1) & 0x1FF)+1, so raw 0 gives 512;
- go to START.

REQ-012 In GET_WH, the word counter SHALL be loaded with ceil(W*H/2):
- 19-bit arithmetic;
- maximum 262144.

REQ-013 START SHALL:
- assert o_activateCopyCV for exactly one cycle;
- go to STREAM.

REQ-014 Register outputs SHALL be stable from START until the next accepted GET_XY/GET_WH word.

REQ-015 STREAM SHALL, on each accepted word:
- assert o_fifowrite in the same cycle (combinational pass-through);
- drive o_fifoDataIn = i_gp0Data;
- decrement the counter.

REQ-016 o_fifowrite SHALL never assert when i_canWriteFIFO=0.

REQ-017 When the word with counter==1 is accepted, the next state SHALL be DRAIN.

REQ-018 For an odd W*H, the last word SHALL be written in full; the copy SM ignores the upper half.

REQ-019 DRAIN SHALL return to IDLE in the cycle after either:
- i_copyInactiveNextCycle=1, or
- i_copyActive=0.

REQ-020 Words presented during START or DRAIN SHALL be held off, not dropped.

REQ-021 A new copy command SHALL NOT be accepted until the state is back in IDLE.

REQ-022 Latency:
- command word to o_activateCopyCV: 3 accepted words plus 1 cycle;
- data word to FIFO write: 0 cycles.

REQ-023 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 When i_rst=1 at a clock edge, the block SHALL set:
- state = IDLE;
- counter = 0;
- o_RegX0 = 0, o_RegY0 = 0;
- o_RegSizeW = 0, o_RegSizeH = 0;
- o_activateCopyCV = 0, o_fifowrite = 0, o_dropCmd = 0, o_busy = 0.

REQ-025 Reset mid-transfer SHALL abandon the transfer immediately, with no further FIFO writes; remaining GP0 words are then treated as IDLE-state commands.

Verification
REQ-026 Basic copy:
- stimulus: words A0000000, 00200010, 00020003, then 3 data words, FIFO always ready;
- required: X=16, Y=32, W=3, H=2;
- required: one activate pulse, exactly 3 o_fifowrite, then DRAIN;
- required: IDLE one cycle after i_copyActive=0.

REQ-027 Size wrap:
- stimulus: WH word 00000000;
- required: W=1024, H=512, counter=262144.

REQ-028 Odd count:
- stimulus: W=3, H=1;
- required: counter=2, exactly 2 writes.

REQ-029 Backpressure:
- stimulus: i_canWriteFIFO toggles 1,0,1,0 during STREAM with i_gp0Valid held at 1;
- required: o_gp0Ready mirrors i_canWriteFIFO, and no write occurs while it is 0.

REQ-030 Non-copy command:
- stimulus: word E1000000 in IDLE;
- required: o_dropCmd pulses once, state stays IDLE, registers unchanged.

REQ-031 Reset mid-transfer:
- stimulus: i_rst=1 after 1 of 4 data words;
- required: next cycle state is IDLE, all outputs 0, no further writes.

Source files
------------

// File: rtl/gpu_cv_cmd_loader.sv
// CPU->VRAM copy command loader.
// Collects the three-word GP0 copy header (command, XY, WH), latches the
// destination rectangle, kicks the copy state machine and then streams the
// pixel-pair payload words straight into the pixel FIFO until the computed
// word count is exhausted. Non-copy words seen while idle are discarded.
module gpu_cv_cmd_loader (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_gp0Valid,
  input  logic [31:0]        i_gp0Data,
  output logic               o_gp0Ready,
  output logic               o_activateCopyCV,
  input  logic               i_copyActive,
  input  logic               i_copyInactiveNextCycle,
  output logic signed [11:0] o_RegX0,
  output logic signed [11:0] o_RegY0,
  output logic [10:0]        o_RegSizeW,
  output logic [9:0]         o_RegSizeH,
  input  logic               i_canWriteFIFO,
  output logic               o_fifowrite,
  output logic [31:0]        o_fifoDataIn,
  output logic               o_busy,
  output logic               o_dropCmd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_XY = 3'd1,
    GET_WH = 3'd2,
    START  = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5
  } loaderState;

  loaderState  state;
  loaderState  nextState;
  logic        stateReady;
  logic        wordAccepted;
  logic        isCopyCmd;
  logic [18:0] wordCount;
  logic [10:0] sizeWNext;
  logic [9:0]  sizeHNext;
  logic [19:0] pixelCount;
  logic [18:0] loadCount;
  logic        dropCmdReg;

  // Size decode: a raw size of 0 wraps to the maximum (1024 x 512).
  always_comb begin
    sizeWNext  = {1'b0, (i_gp0Data[9:0] - 10'd1)} + 11'd1;
    sizeHNext  = {1'b0, (i_gp0Data[24:16] - 9'd1)} + 10'd1;
    pixelCount = {9'd0, sizeWNext} * {10'd0, sizeHNext};
    loadCount  = 19'((pixelCount + 20'd1) >> 1);
  end

  // Per-state readiness; nothing is taken while reset is asserted.
  always_comb begin
    stateReady = 1'b0;
    case (state)
      IDLE, GET_XY, GET_WH: stateReady = 1'b1;
      STREAM:               stateReady = i_canWriteFIFO;
      default:              stateReady = 1'b0;
    endcase
  end

  assign o_gp0Ready       = stateReady & ~i_rst;
  assign wordAccepted     = i_gp0Valid & o_gp0Ready;
  assign isCopyCmd        = (i_gp0Data[31:29] == 3'b101);
  assign o_fifowrite      = (state == STREAM) & wordAccepted;
  assign o_fifoDataIn     = i_gp0Data;
  assign o_activateCopyCV = (state == START);
  assign o_busy           = (state != IDLE);
  assign o_dropCmd        = dropCmdReg;

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (wordAccepted && isCopyCmd) nextState = GET_XY;
        else                           nextState = IDLE;
      end
      GET_XY: begin
        if (wordAccepted) nextState = GET_WH;
        else              nextState = GET_XY;
      end
      GET_WH: begin
        if (wordAccepted) nextState = START;
        else              nextState = GET_WH;
      end
      START: nextState = STREAM;
      STREAM: begin
        if (wordAccepted && (wordCount == 19'd1)) nextState = DRAIN;
        else                                      nextState = STREAM;
      end
      DRAIN: begin
        if (i_copyInactiveNextCycle || !i_copyActive) nextState = IDLE;
        else                                          nextState = DRAIN;
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nextState;
  end

  // Destination rectangle registers, updated only by accepted header words.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_RegX0    <= 12'sd0;
      o_RegY0    <= 12'sd0;
      o_RegSizeW <= 11'd0;
      o_RegSizeH <= 10'd0;
    end else if ((state == GET_XY) && wordAccepted) begin
      o_RegX0 <= {2'b00, i_gp0Data[9:0]};
      o_RegY0 <= {3'b000, i_gp0Data[24:16]};
    end else if ((state == GET_WH) && wordAccepted) begin
      o_RegSizeW <= sizeWNext;
      o_RegSizeH <= sizeHNext;
    end
  end

  // Remaining payload words: loaded from the WH word, counted down per write.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                    wordCount <= 19'd0;
    else if ((state == GET_WH) && wordAccepted)   wordCount <= loadCount;
    else if ((state == STREAM) && wordAccepted)   wordCount <= wordCount - 19'd1;
  end

  // One-cycle pulse after a non-copy word is discarded in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) dropCmdReg <= 1'b0;
    else       dropCmdReg <= (state == IDLE) && wordAccepted && !isCopyCmd;
  end

endmodule

// File: tb/tb_gpu_cv_cmd_loader.sv
// Bench for gpu_cv_cmd_loader: transaction-level model compared every cycle,
// plus hand-computed literal expectations for each directed scenario.
module tb_gpu_cv_cmd_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, valid, gp0Ready, actPulse, copyActive, inactNext;
  logic [31:0]        data, fifoData;
  logic signed [11:0] regX, regY;
  logic [10:0]        regW;
  logic [9:0]         regH;
  logic               canWrite, fifoWrite, busy, dropCmd;

  gpu_cv_cmd_loader dut (
    .i_clk(clk), .i_rst(rst),
    .i_gp0Valid(valid), .i_gp0Data(data), .o_gp0Ready(gp0Ready),
    .o_activateCopyCV(actPulse), .i_copyActive(copyActive),
    .i_copyInactiveNextCycle(inactNext),
    .o_RegX0(regX), .o_RegY0(regY), .o_RegSizeW(regW), .o_RegSizeH(regH),
    .i_canWriteFIFO(canWrite), .o_fifowrite(fifoWrite), .o_fifoDataIn(fifoData),
    .o_busy(busy), .o_dropCmd(dropCmd)
  );

  int checks = 0, failures = 0;
  int writeCount = 0, actCount = 0, dropCount = 0;
  bit checkEn = 1'b0;

  // Model: header words taken (0..3), whether the copy was kicked, payload left.
  int mHdr = 0, mLeft = 0, mX = 0, mY = 0, mW = 0, mH = 0;
  bit mStarted = 1'b0, mDrop = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit expReady();
    if (rst) return 1'b0;
    if (mHdr < 3) return 1'b1;
    if (mStarted && mLeft > 0) return canWrite;
    return 1'b0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      bit eReady, eWrite;
      eReady = expReady();
      eWrite = mStarted && (mLeft > 0) && valid && eReady;
      check("ready", gp0Ready, eReady);
      check("fifowrite", fifoWrite, eWrite);
      if (eWrite) check("fifodata", fifoData, data);
      check("activate", actPulse, (mHdr == 3) && !mStarted);
      check("busy", busy, mHdr != 0);
      check("dropCmd", dropCmd, mDrop);
      check("regX", regX, mX);
      check("regY", regY, mY);
      check("regW", regW, mW);
      check("regH", regH, mH);
      if (fifoWrite) writeCount++;
      if (actPulse)  actCount++;
      if (dropCmd)   dropCount++;
    end
  end

  // Model update on each clock edge.
  always @(posedge clk) begin
    bit acc;
    acc = valid && expReady();
    if (rst) begin
      mHdr = 0; mStarted = 1'b0; mLeft = 0; mDrop = 1'b0;
      mX = 0; mY = 0; mW = 0; mH = 0;
    end else begin
      mDrop = 1'b0;
      if (mHdr == 0) begin
        if (acc) begin
          if (data[31:29] == 3'b101) mHdr = 1;
          else                       mDrop = 1'b1;
        end
      end else if (mHdr == 1) begin
        if (acc) begin
          mX = data[9:0]; mY = data[24:16]; mHdr = 2;
        end
      end else if (mHdr == 2) begin
        if (acc) begin
          mW = data[15:0] % 1024; if (mW == 0) mW = 1024;
          mH = data[31:16] % 512; if (mH == 0) mH = 512;
          mLeft = (mW * mH + 1) / 2;
          mHdr = 3;
        end
      end else if (!mStarted) begin
        mStarted = 1'b1;
      end else if (mLeft > 0) begin
        if (acc) mLeft--;
      end else if (inactNext || !copyActive) begin
        mHdr = 0; mStarted = 1'b0;
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d, input bit cw, input bit ca,
                     input bit inx, input bit r = 1'b0);
    valid = v; data = d; canWrite = cw; copyActive = ca; inactNext = inx; rst = r;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = 32'd0; canWrite = 1'b1;
    copyActive = 1'b0; inactNext = 1'b0;
    @(posedge clk); #1;
    checkEn = 1'b1;
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset busy", busy, 0);
    check("reset regW", regW, 0);

    // Basic copy: X=16 Y=32 W=3 H=2 -> 3 words.
    writeCount = 0; actCount = 0;
    cyc(1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0010, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0002_0003, 1'b1, 1'b1, 1'b0);
    check("t1 count", dut.wordCount, 3);
    cyc(1'b1, 32'h1111_2222, 1'b1, 1'b1, 1'b0);  // START: held off
    cyc(1'b1, 32'h1111_2222, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h3333_4444, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h5555_6666, 1'b1, 1'b1, 1'b0);
    check("t1 drain busy", busy, 1);
    cyc(1'b1, 32'h7777_8888, 1'b1, 1'b1, 1'b0);  // DRAIN: held off
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t1 idle busy", busy, 0);
    check("t1 X", regX, 16);
    check("t1 Y", regY, 32);
    check("t1 W", regW, 3);
    check("t1 H", regH, 2);
    check("t1 writes", writeCount, 3);
    check("t1 activates", actCount, 1);

    // Size wrap: WH word 0 -> 1024 x 512, 262144 words; abandoned by reset.
    cyc(1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    check("t2 W", regW, 1024);
    check("t2 H", regH, 512);
    check("t2 count", dut.wordCount, 262144);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Odd count: W=3 H=1 -> 2 words, finish via copyInactiveNextCycle.
    writeCount = 0;
    cyc(1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0005_0007, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0001_0003, 1'b1, 1'b1, 1'b0);
    check("t3 count", dut.wordCount, 2);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hAAAA_0001, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hCCCC_0003, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    check("t3 writes", writeCount, 2);
    check("t3 X", regX, 7);
    check("t3 Y", regY, 5);
    check("t3 idle busy", busy, 0);

    // Backpressure: W=4 H=2 -> 4 words, FIFO ready toggling.
    writeCount = 0;
    cyc(1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0009_0005, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0002_0004, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0001, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0001, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0002, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0002, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0003, 1'b0, 1'b1, 1'b0);
    check("t4 writes mid", writeCount, 2);
    cyc(1'b1, 32'hD000_0003, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0004, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t4 writes", writeCount, 4);

    // Non-copy command in IDLE.
    dropCount = 0;
    cyc(1'b1, 32'hE100_0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t5 drops", dropCount, 1);
    check("t5 busy", busy, 0);
    check("t5 X kept", regX, 5);
    check("t5 Y kept", regY, 9);

    // Reset after 1 of 4 data words.
    writeCount = 0; dropCount = 0;
    cyc(1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0003_0004, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0002_0004, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0F0F_0001, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0F0F_0002, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6 busy", busy, 0);
    check("t6 activate", actPulse, 0);
    check("t6 dropCmd", dropCmd, 0);
    check("t6 X", regX, 0);
    check("t6 W", regW, 0);
    check("t6 count", dut.wordCount, 0);
    cyc(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    check("t6 writes", writeCount, 1);
    check("t6 drops", dropCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
